// File: rtl/sc_lives_levels_counter.sv
// Lives/levels bookkeeping for the general game state machine: counts active-low
// strobes (one op per low pulse) and returns registered lose/win comparators.
module sc_lives_levels_counter #(
  parameter int INIT_LIVES = 3,
  parameter int MAX_LEVEL  = 4,
  parameter int LIVES_W    = 2,
  parameter int LEVEL_W    = 3
) (
  input  logic               SC_STATEMACHINEGENERAL_CLOCK_50,
  input  logic               SC_STATEMACHINEGENERAL_RESET_InHigh,
  input  logic               clear_InLow,
  input  logic               contador_vidas_InLow,
  input  logic               contador_niveles_InLow,
  output logic [LIVES_W-1:0] lives_Out,
  output logic [LEVEL_W-1:0] level_Out,
  output logic               COMPARATOR_LIVES,
  output logic               COMPARATOR_LEVELS
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } strobe_state_t;

  localparam logic [LIVES_W-1:0] LIVES_RESET = LIVES_W'(INIT_LIVES);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX   = LEVEL_W'(MAX_LEVEL);

  strobe_state_t vidas_state, vidas_next;
  strobe_state_t niveles_state, niveles_next;

  logic               vidas_fire;
  logic               niveles_fire;
  logic [LIVES_W-1:0] lives_next;
  logic [LEVEL_W-1:0] level_next;

  // Release FSMs: an op fires only on the IDLE->HOLD step, so a long pulse counts once.
  // Under clear a still-low strobe parks in HOLD so it is not counted after release.
  always_comb begin
    vidas_next   = vidas_state;
    niveles_next = niveles_state;
    vidas_fire   = 1'b0;
    niveles_fire = 1'b0;

    if (!clear_InLow) begin
      vidas_next   = contador_vidas_InLow   ? IDLE : HOLD;
      niveles_next = contador_niveles_InLow ? IDLE : HOLD;
    end else begin
      case (vidas_state)
        IDLE: begin
          if (!contador_vidas_InLow) begin
            vidas_fire = 1'b1;
            vidas_next = HOLD;
          end
        end
        HOLD: begin
          if (contador_vidas_InLow) vidas_next = IDLE;
        end
        default: vidas_next = IDLE;
      endcase

      case (niveles_state)
        IDLE: begin
          if (!contador_niveles_InLow) begin
            niveles_fire = 1'b1;
            niveles_next = HOLD;
          end
        end
        HOLD: begin
          if (contador_niveles_InLow) niveles_next = IDLE;
        end
        default: niveles_next = IDLE;
      endcase
    end
  end

  // Saturating counter updates; clear wins over both strobes.
  always_comb begin
    lives_next = lives_Out;
    level_next = level_Out;
    if (!clear_InLow) begin
      lives_next = LIVES_RESET;
      level_next = '0;
    end else begin
      if (vidas_fire && (lives_Out != '0))
        lives_next = lives_Out - 1'b1;
      if (niveles_fire && (level_Out != LEVEL_MAX))
        level_next = level_Out + 1'b1;
    end
  end

  // Comparators are registered from the next counter values so they never lag the counters.
  always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
    if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
      vidas_state       <= IDLE;
      niveles_state     <= IDLE;
      lives_Out         <= LIVES_RESET;
      level_Out         <= '0;
      COMPARATOR_LIVES  <= (LIVES_RESET == '0);
      COMPARATOR_LEVELS <= 1'b1;
    end else begin
      vidas_state       <= vidas_next;
      niveles_state     <= niveles_next;
      lives_Out         <= lives_next;
      level_Out         <= level_next;
      COMPARATOR_LIVES  <= (lives_next == '0);
      COMPARATOR_LEVELS <= (level_next != LEVEL_MAX);
    end
  end

endmodule

// File: tb/tb_sc_lives_levels_counter.sv
// Directed self-checking bench for sc_lives_levels_counter (default parameters).
`timescale 1ns/1ps
module tb_sc_lives_levels_counter;

  logic       clock;
  logic       reset;
  logic       clear_n;
  logic       vidas_n;
  logic       niveles_n;
  logic [1:0] lives;
  logic [2:0] level;
  logic       cmp_lives;
  logic       cmp_levels;

  int checks   = 0;
  int failures = 0;

  sc_lives_levels_counter #(
    .INIT_LIVES(3),
    .MAX_LEVEL (4),
    .LIVES_W   (2),
    .LEVEL_W   (3)
  ) dut (
    .SC_STATEMACHINEGENERAL_CLOCK_50    (clock),
    .SC_STATEMACHINEGENERAL_RESET_InHigh(reset),
    .clear_InLow                        (clear_n),
    .contador_vidas_InLow               (vidas_n),
    .contador_niveles_InLow             (niveles_n),
    .lives_Out                          (lives),
    .level_Out                          (level),
    .COMPARATOR_LIVES                   (cmp_lives),
    .COMPARATOR_LEVELS                  (cmp_levels)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v_n, input logic n_n, input logic c_n);
    vidas_n   = v_n;
    niveles_n = n_n;
    clear_n   = c_n;
  endtask

  // Advance one edge and land 1 ns after it, away from the sampling point.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic pulseVidas();
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
  endtask

  task automatic pulseNiveles();
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    #3;

    // 1: reset state, then three single-cycle life pulses
    doReset();
    checkOutput("reset_lives", lives, 3);
    checkOutput("reset_level", level, 0);
    checkOutput("reset_cmp_lives", cmp_lives, 0);
    checkOutput("reset_cmp_levels", cmp_levels, 1);
    pulseVidas();
    checkOutput("t1_lives_2", lives, 2);
    checkOutput("t1_cmp_lives_2", cmp_lives, 0);
    tick(2);
    pulseVidas();
    checkOutput("t1_lives_1", lives, 1);
    checkOutput("t1_cmp_lives_1", cmp_lives, 0);
    tick(1);
    pulseVidas();
    checkOutput("t1_lives_0", lives, 0);
    checkOutput("t1_cmp_lives_0", cmp_lives, 1);

    // 2: long low pulse counts once; saturation at zero
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(1);
    checkOutput("t2_hold_first", lives, 2);
    tick(9);
    checkOutput("t2_hold_last", lives, 2);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(1);
    checkOutput("t2_after_release", lives, 2);
    pulseVidas();
    tick(1);
    pulseVidas();
    checkOutput("t2_lives_0", lives, 0);
    tick(1);
    pulseVidas();
    checkOutput("t2_no_wrap", lives, 0);
    checkOutput("t2_cmp_lives", cmp_lives, 1);

    // 3: level pulses up to the win value and saturation
    doReset();
    for (int k = 1; k <= 4; k++) begin
      pulseNiveles();
      checkOutput($sformatf("t3_level_%0d", k), level, k);
      checkOutput($sformatf("t3_cmp_levels_%0d", k), cmp_levels, (k == 4) ? 0 : 1);
      tick(1);
    end
    pulseNiveles();
    checkOutput("t3_level_sat", level, 4);
    checkOutput("t3_cmp_levels_sat", cmp_levels, 0);

    // 4: clear while a life strobe is held low
    doReset();
    pulseVidas();
    tick(1);
    pulseVidas();
    checkOutput("t4_lives_1", lives, 1);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(1);
    checkOutput("t4_clear_lives", lives, 3);
    checkOutput("t4_clear_cmp_lives", cmp_lives, 0);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(3);
    checkOutput("t4_release_no_dec", lives, 3);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(1);
    pulseVidas();
    checkOutput("t4_next_pulse", lives, 2);

    // 5: simultaneous strobes from reset
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t5_lives", lives, 2);
    checkOutput("t5_level", level, 1);

    // 6: async reset mid-cycle during a level pulse at level 3
    doReset();
    for (int k = 0; k < 3; k++) begin
      pulseNiveles();
      tick(1);
    end
    checkOutput("t6_level_3", level, 3);
    applyStimulus(1'b1, 1'b0, 1'b1);
    #5;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_level", level, 0);
    checkOutput("t6_async_lives", lives, 3);
    checkOutput("t6_async_cmp_levels", cmp_levels, 1);
    checkOutput("t6_async_cmp_lives", cmp_lives, 0);
    tick(1);
    #4;
    reset = 1'b0;
    tick(1);
    checkOutput("t6_strobe_after_reset", level, 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
